osd_ctm_trace_rx: RTL and testbench

Receive-side decoder for Core Trace Module (CTM) event packets on the debug interconnect. It consumes a dii_flit stream addressed to this module's id and parses trace-event and overflow packets into parallel trace records with a valid/ready handshake. Malformed packets are discarded and counted. It sits at a host-side or on-chip trace sink: the debug ring feeds its input, and a trace buffer or analysis logic consumes its output.

---
 rtl/osd_ctm_trace_rx.sv | 210 +++++++++++++++++++++
 tb/tb_osd_ctm_trace_rx.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_ctm_trace_rx.sv
// osd_ctm_trace_rx: parses CTM trace-event and overflow packets arriving on
// the debug interconnect into parallel trace records with valid/ready output.
// Malformed packets are dropped and counted in a saturating error counter.

package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_ctm_trace_rx
  import dii_package::*;
#(
  parameter int MAX_PKT_LEN = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  input  dii_flit     debug_in,
  output logic        debug_in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_overflow,
  output logic [15:0] out_src,
  output logic [31:0] out_time,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic        out_jal,
  output logic        out_jalr,
  output logic [1:0]  out_prv,
  output logic [15:0] out_ovf_count,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    HDR_DEST,
    HDR_SRC,
    HDR_TYPE,
    PAYLOAD,
    DRAIN,
    OUT
  } state_t;

  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(MAX_PKT_LEN - 1);

  state_t        r_state;
  logic          r_outValid;
  logic          r_overflow;
  logic [2:0]    r_idx;
  logic [2:0]    r_expLen;
  logic [CW-1:0] r_drainCnt;
  logic [15:0]   r_src;
  logic [15:0]   r_ovfCount;
  logic [15:0]   r_errCount;
  logic [31:0]   r_time;
  logic [31:0]   r_pc;
  logic [31:0]   r_npc;
  logic [3:0]    r_flags;

  logic w_accept;
  logic w_hdrOk;
  logic w_final;

  // The counter sticks at all-ones so a flood of bad packets never wraps to a small value.
  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Input is stalled only while a finished record waits for the consumer.
  assign w_accept = debug_in.valid && !r_outValid;
  // Event packets (TYPE 2'b10) with SUBTYPE 0 (trace) or 1 (overflow) are understood.
  assign w_hdrOk  = (debug_in.data[15:14] == 2'b10) && (debug_in.data[13:11] == 3'b000);
  assign w_final  = (r_idx == r_expLen - 3'd1);

  assign debug_in_ready = ~r_outValid;
  assign out_valid      = r_outValid;
  assign out_overflow   = r_overflow;
  assign out_src        = r_src;
  assign out_time       = r_time;
  assign out_pc         = r_pc;
  assign out_npc        = r_npc;
  assign out_jal        = r_flags[0];
  assign out_jalr       = r_flags[1];
  assign out_prv        = r_flags[3:2];
  assign out_ovf_count  = r_ovfCount;
  assign err_count      = r_errCount;

  // Packet parser: walks header and payload flits, fills the record and holds it until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HDR_DEST;
      r_outValid <= 1'b0;
      r_overflow <= 1'b0;
      r_idx      <= '0;
      r_expLen   <= '0;
      r_drainCnt <= '0;
      r_src      <= '0;
      r_ovfCount <= '0;
      r_errCount <= '0;
      r_time     <= '0;
      r_pc       <= '0;
      r_npc      <= '0;
      r_flags    <= '0;
    end else begin
      case (r_state)
        HDR_DEST: begin
          if (w_accept && !debug_in.last) begin
            if (debug_in.data == id) begin
              r_state <= HDR_SRC;
            end else begin
              r_state    <= DRAIN;
              r_drainCnt <= '0;
            end
          end
        end
        HDR_SRC: begin
          if (w_accept) begin
            r_src <= debug_in.data;
            if (debug_in.last) begin
              r_errCount <= satInc(r_errCount);
              r_state    <= HDR_DEST;
            end else begin
              r_state <= HDR_TYPE;
            end
          end
        end
        HDR_TYPE: begin
          if (w_accept) begin
            if (debug_in.last) begin
              r_errCount <= satInc(r_errCount);
              r_state    <= HDR_DEST;
            end else if (w_hdrOk) begin
              r_state    <= PAYLOAD;
              r_overflow <= debug_in.data[10];
              r_expLen   <= debug_in.data[10] ? 3'd1 : 3'd7;
              r_idx      <= '0;
              r_time     <= '0;
              r_pc       <= '0;
              r_npc      <= '0;
              r_flags    <= '0;
              r_ovfCount <= '0;
            end else begin
              r_errCount <= satInc(r_errCount);
              r_state    <= DRAIN;
              r_drainCnt <= '0;
            end
          end
        end
        PAYLOAD: begin
          if (w_accept) begin
            if (r_overflow) begin
              r_ovfCount <= debug_in.data;
            end else begin
              case (r_idx)
                3'd0:    r_time[15:0]  <= debug_in.data;
                3'd1:    r_time[31:16] <= debug_in.data;
                3'd2:    r_npc[15:0]   <= debug_in.data;
                3'd3:    r_npc[31:16]  <= debug_in.data;
                3'd4:    r_pc[15:0]    <= debug_in.data;
                3'd5:    r_pc[31:16]   <= debug_in.data;
                default: r_flags       <= debug_in.data[3:0];
              endcase
            end
            if (w_final) begin
              if (debug_in.last) begin
                r_state    <= OUT;
                r_outValid <= 1'b1;
              end else begin
                r_errCount <= satInc(r_errCount);
                r_state    <= DRAIN;
                r_drainCnt <= '0;
              end
            end else if (debug_in.last) begin
              r_errCount <= satInc(r_errCount);
              r_state    <= HDR_DEST;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (w_accept) begin
            if (debug_in.last) begin
              r_state <= HDR_DEST;
            end else if (r_drainCnt == DRAIN_LAST) begin
              r_errCount <= satInc(r_errCount);
              r_state    <= HDR_DEST;
            end else begin
              r_drainCnt <= r_drainCnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= HDR_DEST;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_state    <= HDR_DEST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_ctm_trace_rx.sv
// tb_osd_ctm_trace_rx: directed and randomized packet streams for the CTM trace
// receiver, checked every cycle against a packet-level reference model.

module tb_osd_ctm_trace_rx;
  import dii_package::*;

  localparam int          MAXLEN = 12;
  localparam logic [15:0] OWN_ID = 16'h0005;

  typedef logic [15:0] flitQ_t[$];

  typedef struct packed {
    logic        ovf;
    logic [15:0] src;
    logic [31:0] tim;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        jal;
    logic        jalr;
    logic [1:0]  prv;
    logic [15:0] cnt;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ownId = OWN_ID;
  dii_flit     debug_in = '0;
  logic        debug_in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_overflow;
  logic [15:0] out_src;
  logic [31:0] out_time;
  logic [31:0] out_pc;
  logic [31:0] out_npc;
  logic        out_jal;
  logic        out_jalr;
  logic [1:0]  out_prv;
  logic [15:0] out_ovf_count;
  logic [15:0] err_count;

  int nCompared   = 0;
  int nMismatched = 0;
  bit randReady   = 1'b0;
  bit randGaps    = 1'b0;
  bit bDone       = 1'b0;
  int preloadSeq  = 0;

  // Reference model state: flits of the packet being collected, drain tracking, pending records.
  flitQ_t      mQ;
  bit          mDrain = 1'b0;
  int          mDcnt = 0;
  int          mTotal = 0;
  rec_t        expQ[$];
  logic [15:0] mErr = '0;
  int          preloadSeen = 0;
  rec_t        cr;
  flitQ_t      pkt;
  flitQ_t      pktB;

  osd_ctm_trace_rx #(.MAX_PKT_LEN(MAXLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .id             (ownId),
    .debug_in       (debug_in),
    .debug_in_ready (debug_in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_overflow   (out_overflow),
    .out_src        (out_src),
    .out_time       (out_time),
    .out_pc         (out_pc),
    .out_npc        (out_npc),
    .out_jal        (out_jal),
    .out_jalr       (out_jalr),
    .out_prv        (out_prv),
    .out_ovf_count  (out_ovf_count),
    .err_count      (err_count)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelErr();
    if (mErr != 16'hFFFF) mErr = mErr + 16'd1;
  endfunction

  function automatic void modelStartDrain();
    mQ.delete();
    mDrain = 1'b1;
    mDcnt  = 0;
  endfunction

  // Packet-level interpretation of one accepted flit, judged by its position within the packet.
  function automatic void modelFlit(input logic last, input logic [15:0] data);
    int   n;
    rec_t r;
    if (mDrain) begin
      if (last) begin
        mDrain = 1'b0;
      end else begin
        mDcnt++;
        if (mDcnt == MAXLEN) begin
          modelErr();
          mDrain = 1'b0;
        end
      end
      return;
    end
    mQ.push_back(data);
    n = mQ.size();
    if (n == 1) begin
      if (last) mQ.delete();
      else if (data != ownId) modelStartDrain();
    end else if (n == 2) begin
      if (last) begin modelErr(); mQ.delete(); end
    end else if (n == 3) begin
      if (last) begin
        modelErr();
        mQ.delete();
      end else if (data[15:14] != 2'b10 || data[13:10] > 4'd1) begin
        modelErr();
        modelStartDrain();
      end else begin
        mTotal = (data[13:10] == 4'd0) ? 10 : 4;
      end
    end else if (n == mTotal) begin
      if (last) begin
        r     = '0;
        r.src = mQ[1];
        if (mTotal == 4) begin
          r.ovf = 1'b1;
          r.cnt = mQ[3];
        end else begin
          r.tim  = {mQ[4], mQ[3]};
          r.npc  = {mQ[6], mQ[5]};
          r.pc   = {mQ[8], mQ[7]};
          r.jal  = mQ[9][0];
          r.jalr = mQ[9][1];
          r.prv  = mQ[9][3:2];
        end
        expQ.push_back(r);
        mQ.delete();
      end else begin
        modelErr();
        modelStartDrain();
      end
    end else if (last) begin
      modelErr();
      mQ.delete();
    end
  endfunction

  // Model advances on each clock edge using the handshakes as the specification defines them.
  always @(posedge clk or posedge rst) begin
    bit rdy;
    if (rst) begin
      mQ.delete();
      mDrain = 1'b0;
      mDcnt  = 0;
      mTotal = 0;
      expQ.delete();
      mErr   = '0;
    end else begin
      if (preloadSeen != preloadSeq) begin
        mErr        = 16'hFFFD;
        preloadSeen = preloadSeq;
      end
      rdy = (expQ.size() == 0);
      if (!rdy && out_ready) void'(expQ.pop_front());
      if (debug_in.valid && rdy) modelFlit(debug_in.last, debug_in.data);
    end
  end

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    checkOutput("out_valid", 64'(out_valid), 64'(expQ.size() != 0));
    checkOutput("debug_in_ready", 64'(debug_in_ready), 64'(expQ.size() == 0));
    checkOutput("err_count", 64'(err_count), 64'(mErr));
    if (expQ.size() != 0) begin
      cr = expQ[0];
      checkOutput("out_overflow", 64'(out_overflow), 64'(cr.ovf));
      checkOutput("out_src", 64'(out_src), 64'(cr.src));
      checkOutput("out_time", 64'(out_time), 64'(cr.tim));
      checkOutput("out_pc", 64'(out_pc), 64'(cr.pc));
      checkOutput("out_npc", 64'(out_npc), 64'(cr.npc));
      checkOutput("out_jal", 64'(out_jal), 64'(cr.jal));
      checkOutput("out_jalr", 64'(out_jalr), 64'(cr.jalr));
      checkOutput("out_prv", 64'(out_prv), 64'(cr.prv));
      checkOutput("out_ovf_count", 64'(out_ovf_count), 64'(cr.cnt));
    end
  end

  // Drives one flit from a negedge and returns at the negedge after it was accepted.
  task automatic applyStimulus(input logic last, input logic [15:0] data);
    bit rdy;
    int budget;
    debug_in.valid = 1'b1;
    debug_in.last  = last;
    debug_in.data  = data;
    budget = 0;
    forever begin
      rdy = debug_in_ready;
      @(negedge clk);
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
      if (rdy) break;
      budget++;
      if (budget > 500) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL flit_accept_timeout: got no ready, expected ready within 500 cycles");
        break;
      end
    end
    debug_in.valid = 1'b0;
  endtask

  task automatic idleCycle();
    debug_in.valid = 1'b0;
    debug_in.last  = 1'($urandom_range(0, 1));
    debug_in.data  = 16'($urandom);
    @(negedge clk);
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic sendPacket(input flitQ_t f, input int lastAt);
    for (int i = 0; i < f.size(); i++) begin
      if (randGaps && $urandom_range(0, 4) == 0) idleCycle();
      applyStimulus(i == lastAt, f[i]);
    end
  endtask

  task automatic randomPacket();
    flitQ_t      f;
    int          kind;
    int          lastAt;
    logic [15:0] hdr;
    kind = $urandom_range(0, 9);
    hdr  = 16'h8000 | 16'($urandom_range(0, 1023));
    f.delete();
    case (kind)
      0, 1, 2, 3: begin
        f = {OWN_ID, 16'($urandom), hdr};
        repeat (7) f.push_back(16'($urandom));
        lastAt = 9;
      end
      4, 5: begin
        hdr[10] = 1'b1;
        f = {OWN_ID, 16'($urandom), hdr, 16'($urandom)};
        lastAt = 3;
      end
      6: begin
        f = {OWN_ID ^ 16'($urandom_range(1, 65535))};
        repeat ($urandom_range(0, 13)) f.push_back(16'($urandom));
        lastAt = f.size() - 1;
      end
      7: begin
        hdr = 16'($urandom);
        if (hdr[15:14] == 2'b10 && hdr[13:11] == 3'b000) hdr[15] = 1'b0;
        f = {OWN_ID, 16'($urandom), hdr};
        repeat ($urandom_range(0, 3)) f.push_back(16'($urandom));
        lastAt = f.size() - 1;
      end
      8: begin
        f = {OWN_ID, 16'($urandom), hdr};
        repeat (7) f.push_back(16'($urandom));
        lastAt = $urandom_range(0, 8);
      end
      default: begin
        f = {OWN_ID, 16'($urandom), hdr};
        repeat (7) f.push_back(16'($urandom));
        repeat ($urandom_range(0, 16)) f.push_back(16'($urandom));
        f.push_back(16'($urandom));
        lastAt = f.size() - 1;
      end
    endcase
    sendPacket(f, lastAt);
  endtask

  // Safety net: a run that never finishes is reported and stopped.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 60000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then a long randomized stream.
  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset debug_in_ready", 64'(debug_in_ready), 64'd1);
    checkOutput("reset err_count", 64'(err_count), 64'd0);
    checkOutput("reset out_time", 64'(out_time), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    pkt = {16'h0005, 16'h0001, 16'h8000, 16'h1234, 16'h0000, 16'h2000, 16'h0000, 16'h1FFC, 16'h0000, 16'h000D};
    sendPacket(pkt, 9);
    checkOutput("trace out_valid", 64'(out_valid), 64'd1);
    checkOutput("trace out_src", 64'(out_src), 64'h1);
    checkOutput("trace out_time", 64'(out_time), 64'h1234);
    checkOutput("trace out_npc", 64'(out_npc), 64'h2000);
    checkOutput("trace out_pc", 64'(out_pc), 64'h1FFC);
    checkOutput("trace out_jal", 64'(out_jal), 64'd1);
    checkOutput("trace out_jalr", 64'(out_jalr), 64'd0);
    checkOutput("trace out_prv", 64'(out_prv), 64'd3);
    checkOutput("trace out_overflow", 64'(out_overflow), 64'd0);
    checkOutput("trace err_count", 64'(err_count), 64'd0);
    idleCycle();
    checkOutput("after handshake out_valid", 64'(out_valid), 64'd0);

    pkt = {16'h0005, 16'h0002, 16'h8400, 16'h0017};
    sendPacket(pkt, 3);
    checkOutput("ovf out_overflow", 64'(out_overflow), 64'd1);
    checkOutput("ovf out_ovf_count", 64'(out_ovf_count), 64'h17);
    checkOutput("ovf out_src", 64'(out_src), 64'h2);
    checkOutput("ovf out_time", 64'(out_time), 64'd0);
    checkOutput("ovf out_pc", 64'(out_pc), 64'd0);
    checkOutput("ovf out_npc", 64'(out_npc), 64'd0);
    checkOutput("ovf out_prv", 64'(out_prv), 64'd0);
    idleCycle();

    out_ready = 1'b0;
    pkt = {16'h0005, 16'h0004, 16'h8000, 16'h0001, 16'hBEEF, 16'h2222, 16'h1111, 16'h4444, 16'h3333, 16'h0006};
    sendPacket(pkt, 9);
    pktB = {16'h0005, 16'h0003, 16'h8400, 16'h00AB};
    fork
      begin
        sendPacket(pktB, 3);
        bDone = 1'b1;
      end
    join_none
    repeat (5) begin
      checkOutput("bp debug_in_ready", 64'(debug_in_ready), 64'd0);
      checkOutput("bp out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp out_time", 64'(out_time), 64'hBEEF0001);
      checkOutput("bp out_pc", 64'(out_pc), 64'h33334444);
      checkOutput("bp out_npc", 64'(out_npc), 64'h11112222);
      checkOutput("bp out_jalr", 64'(out_jalr), 64'd1);
      checkOutput("bp out_prv", 64'(out_prv), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait (bDone);
    checkOutput("second out_valid", 64'(out_valid), 64'd1);
    checkOutput("second out_overflow", 64'(out_overflow), 64'd1);
    checkOutput("second out_ovf_count", 64'(out_ovf_count), 64'hAB);
    checkOutput("second out_src", 64'(out_src), 64'h3);
    idleCycle();

    pkt = {16'h0009};
    for (int i = 1; i < 10; i++) pkt.push_back(16'(i));
    sendPacket(pkt, 9);
    checkOutput("wrong dest out_valid", 64'(out_valid), 64'd0);
    checkOutput("wrong dest err_count", 64'(err_count), 64'd0);

    pkt = {16'h0005, 16'h0001, 16'h4000, 16'h0000, 16'h0000};
    sendPacket(pkt, 4);
    checkOutput("bad type err_count", 64'(err_count), 64'd1);
    checkOutput("bad type out_valid", 64'(out_valid), 64'd0);
    pkt = {16'h0005, 16'h0007, 16'h8400, 16'h0042};
    sendPacket(pkt, 3);
    checkOutput("after bad type ovf_count", 64'(out_ovf_count), 64'h42);
    checkOutput("after bad type out_src", 64'(out_src), 64'h7);
    idleCycle();

    pkt = {16'h0005, 16'h0001, 16'h8000, 16'h1111, 16'h2222, 16'h3333};
    sendPacket(pkt, 5);
    checkOutput("early last err_count", 64'(err_count), 64'd2);
    checkOutput("early last out_valid", 64'(out_valid), 64'd0);
    pkt = {16'h0005, 16'h0001, 16'h8000, 16'h1234, 16'h0000, 16'h2000, 16'h0000, 16'h1FFC, 16'h0000, 16'h000D};
    sendPacket(pkt, 9);
    checkOutput("after early last out_pc", 64'(out_pc), 64'h1FFC);
    idleCycle();

    sendPacket(pkt, -1);
    checkOutput("no last err_count", 64'(err_count), 64'd3);
    checkOutput("no last out_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 16'h0000);
    sendPacket(pkt, 9);
    checkOutput("after no last out_time", 64'(out_time), 64'h1234);
    checkOutput("after no last err_count", 64'(err_count), 64'd3);
    idleCycle();

    randReady = 1'b1;
    randGaps  = 1'b1;
    for (int p = 0; p < 400; p++) randomPacket();
    randReady = 1'b0;
    randGaps  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b1, 16'h0000);
    repeat (2) idleCycle();

    for (int i = 0; i < 7; i++) applyStimulus(1'b0, pkt[i]);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid reset debug_in_ready", 64'(debug_in_ready), 64'd1);
    checkOutput("mid reset err_count", 64'(err_count), 64'd0);
    checkOutput("mid reset out_src", 64'(out_src), 64'd0);
    checkOutput("mid reset out_time", 64'(out_time), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sendPacket(pkt, 9);
    checkOutput("post reset out_valid", 64'(out_valid), 64'd1);
    checkOutput("post reset out_npc", 64'(out_npc), 64'h2000);
    idleCycle();

    out_ready = 1'b0;
    pkt = {16'h0005, 16'h0002, 16'h8400, 16'h0017};
    sendPacket(pkt, 3);
    checkOutput("held record out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("out reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("out reset debug_in_ready", 64'(debug_in_ready), 64'd1);
    checkOutput("out reset out_overflow", 64'(out_overflow), 64'd0);
    checkOutput("out reset out_ovf_count", 64'(out_ovf_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    idleCycle();

    #2 force dut.r_errCount = 16'hFFFD;
    #1 release dut.r_errCount;
    preloadSeq++;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      pkt = {OWN_ID, 16'h0001};
      sendPacket(pkt, 1);
      checkOutput("saturating err_count", 64'(err_count), (k == 0) ? 64'hFFFE : 64'hFFFF);
    end
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
